instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Inverse of the control decoder. Accepts control-field tuples (wrtsrc, alusrc, aluop, payload) over a valid/ready handshake and encodes each into the 32-bit instruction word that the decoder maps back to the same tuple. Writes encoded words sequentially into instruction memory through a single write port. Used by the boot/test loader to fill instruction memory before the core runs.

Parameters:
ADDR_W, 6, instruction memory address width
DEPTH, 64, number of writable words; DEPTH <= 2^ADDR_W
BASE, 0, first write address after start

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load session
in_valid  input  1  tuple present
in_ready  output  1  encoder accepts tuple this cycle
in_wrtsrc  input  1  requested wrtsrc
in_alusrc  input  1  requested alusrc
in_aluop  input  3  requested aluop
in_field  input  25  payload placed in instr[30:6]
in_last  input  1  final tuple of the session
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_W  write address
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written this session
done  output  1  session complete
err  output  1  sticky: inconsistent tuple seen this session

Behaviour:
- Reset (async, any time, including mid-session): state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE, mem_wdata=0, count=0, done=0, err=0. Any pending write is discarded.
- States: IDLE, LOAD, DONE.
  - IDLE: in_ready=0. start -> LOAD; mem_addr<=BASE, count<=0, err<=0, done<=0.
  - LOAD: in_ready=1. start is ignored. Accept = in_valid & in_ready.
  - DONE: in_ready=0, done=1. start -> LOAD with the same clears as from IDLE.
- Encoding is combinational on the accepted tuple; the word is registered:
  - instr[31] = ~in_wrtsrc
  - instr[30:6] = in_field
  - instr[5] = in_aluop[2]
  - instr[4:3] = 00
  - instr[2] = in_aluop[1]
  - instr[1:0] = {0, in_aluop[0]}
- Consistency rule:
  - The decoder forces alusrc = ~instr[5] = ~aluop[2]. A tuple is inconsistent if in_alusrc == in_aluop[2].
  - An inconsistent tuple is still accepted (handshake completes) but is not written: no mem_we, and no advance of address or count. err<=1 and stays set until the next start or rst.
- Write timing: a consistent tuple accepted in cycle N produces mem_we=1 for exactly cycle N+1, with mem_addr = current write address and mem_wdata = encoded word. The address increments after the write. Back-to-back accepts give a contiguous mem_we burst, one word per cycle.
- count increments on each mem_we cycle. It is visible the cycle after the write.
- Session end (leave LOAD for DONE on the accept cycle, so in_ready drops in cycle N+1):
  - in_last on an accepted tuple, whether consistent or not. The final write, if any, still occurs in N+1.
  - the accepted consistent tuple is the DEPTH-th written word.
  - Both conditions in the same cycle: a single transition to DONE.
- No wrap-around. Tuples are never accepted once DEPTH words have been written.
- done rises in the cycle after the transition and stays high until start or rst.
- mem_addr holds its last value when mem_we=0. mem_wdata holds its last value.

Test Plan:
- rst, then start, then one tuple (wrtsrc=1, alusrc=1, aluop=011, field=0, last=1) -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00000005. The following cycle: done=1, count=1, err=0.
- Tuple (wrtsrc=0, alusrc=0, aluop=100, field=0x000001) -> mem_wdata=0x80000060. Feed it to the decoder: wrtsrc=0, alusrc=0, aluop=100.
- Five back-to-back consistent tuples, last on the 5th -> mem_we high for 5 consecutive cycles, addr 0..4. count=5, done=1, in_ready low from the cycle after the 5th accept.
- Tuple alusrc=0 with aluop=000 between two good ones -> err=1 sticky. Only 2 writes, at addrs 0 and 1. count=2.
- DEPTH=4 with no in_last and 6 tuples offered -> exactly 4 writes (addr 0..3), then done=1. in_ready=0 while tuples 5 and 6 are held valid.
- rst asserted asynchronously mid-burst after 2 accepts -> all outputs immediately at reset values, no further mem_we. A new start writes from addr 0 with count=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes control tuples into 32-bit instruction words and writes them sequentially to instruction memory.
// Latency 1 cycle accept->mem_we; backpressure: in_ready high only while loading, no internal buffering.
module instr_encoder_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wrtsrc,
  input  logic              in_alusrc,
  input  logic [2:0]        in_aluop,
  input  logic [24:0]       in_field,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);

  state_t              state_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [31:0]         mem_wdata_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     acc_q;
  logic                done_q;
  logic                err_q;

  logic                accept;
  logic                consistent;
  logic                last_word;
  logic [31:0]         enc_d;

  assign in_ready   = (state_q == LOAD);
  assign accept     = in_valid & in_ready;
  // The decoder derives alusrc from ~instr[5]; a tuple asking otherwise cannot be represented.
  assign consistent = (in_alusrc != in_aluop[2]);
  assign last_word  = (acc_q == LAST_IDX);
  assign enc_d      = {~in_wrtsrc, in_field, in_aluop[2], 2'b00, in_aluop[1], 1'b0, in_aluop[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      wr_ptr_q    <= BASE_ADDR;
      mem_wdata_q <= 32'h0;
      count_q     <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (mem_we_q) count_q <= count_q + 1'b1;
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (consistent) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wr_ptr_q;
              mem_wdata_q <= enc_d;
              wr_ptr_q    <= wr_ptr_q + 1'b1;
              acc_q       <= acc_q + 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            if (in_last || (consistent && last_word)) state_q <= DONE;
          end
        end
        DONE: done_q <= 1'b1;
        default: ;
      endcase
      // Session restart clears override the pending count increment above.
      if (start && state_q != LOAD) begin
        state_q    <= LOAD;
        mem_addr_q <= BASE_ADDR;
        wr_ptr_q   <= BASE_ADDR;
        count_q    <= '0;
        acc_q      <= '0;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: default-depth instance plus a DEPTH=4 instance on shared inputs.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_wrtsrc, in_alusrc, in_last;
  logic [2:0]  in_aluop;
  logic [24:0] in_field;

  logic        in_ready, mem_we, done, err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;

  logic        in_ready_b, mem_we_b, done_b, err_b;
  logic [5:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [6:0]  count_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(6), .DEPTH(64), .BASE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_wrtsrc(in_wrtsrc), .in_alusrc(in_alusrc), .in_aluop(in_aluop), .in_field(in_field),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .done(done), .err(err)
  );

  instr_encoder_loader #(.ADDR_W(6), .DEPTH(4), .BASE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_wrtsrc(in_wrtsrc), .in_alusrc(in_alusrc), .in_aluop(in_aluop), .in_field(in_field),
    .in_last(in_last), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .count(count_b), .done(done_b), .err(err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic w, input logic a, input logic [2:0] op,
                       input logic [24:0] f, input logic l);
    in_valid = 1'b1; in_wrtsrc = w; in_alusrc = a; in_aluop = op; in_field = f; in_last = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_wrtsrc = 1'b0; in_alusrc = 1'b0;
    in_aluop = 3'b000; in_field = 25'h0; in_last = 1'b0;
    #3;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== 6'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_tests++; if ({count, done, err} !== 9'd0) begin n_fail++; $display("FAIL reset_cnt_done_err: got %h want 0", {count, done, err}); end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_single();
    do_start();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", in_ready); end
    drive(1'b1, 1'b1, 3'b011, 25'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", mem_we); end
    n_tests++; if (mem_addr !== 6'd0) begin n_fail++; $display("FAIL single_addr: got %0d want 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0000_0005) begin n_fail++; $display("FAIL single_wdata: got %h want 00000005", mem_wdata); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_drop: got %b want 0", in_ready); end
    tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done); end
    n_tests++; if (count !== 7'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b want 0", mem_we); end
  endtask

  task automatic test_encode();
    logic [31:0] w;
    do_start();
    drive(1'b0, 1'b0, 3'b100, 25'h000001, 1'b1);
    tick();
    in_valid = 1'b0;
    w = mem_wdata;
    n_tests++; if (w !== 32'h8000_0060) begin n_fail++; $display("FAIL enc_wdata: got %h want 80000060", w); end
    n_tests++; if ({~w[31], ~w[5], w[5], w[2], w[0]} !== 5'b0_0_100) begin
      n_fail++; $display("FAIL enc_decode: got %b want 00100", {~w[31], ~w[5], w[5], w[2], w[0]}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [5];
    logic [2:0]  ops   [5];
    logic        ws    [5];
    logic        as    [5];
    logic [24:0] fs    [5];
    exp_w = '{32'h0000_0040, 32'h8000_00A5, 32'h0000_00C4, 32'hFFFF_FFC1, 32'h5555_5564};
    ops   = '{3'b000, 3'b111, 3'b010, 3'b001, 3'b110};
    ws    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    as    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    fs    = '{25'h1, 25'h2, 25'h3, 25'h1FFFFFF, 25'h1555555};
    do_start();
    for (int i = 0; i < 5; i++) begin
      drive(ws[i], as[i], ops[i], fs[i], i == 4);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we[%0d]: got %b want 1", i, mem_we); end
      n_tests++; if (mem_addr !== 6'(i)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, mem_addr, i); end
      n_tests++; if (mem_wdata !== exp_w[i]) begin n_fail++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, mem_wdata, exp_w[i]); end
      n_tests++; if (count !== 7'(i)) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, count, i); end
    end
    in_valid = 1'b0;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %b want 0", in_ready); end
    tick();
    n_tests++; if (count !== 7'd5) begin n_fail++; $display("FAIL b2b_count_final: got %0d want 5", count); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_we_end: got %b want 0", mem_we); end
  endtask

  task automatic test_err();
    do_start();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL err_done_clear: got %b want 0", done); end
    drive(1'b1, 1'b1, 3'b000, 25'h1, 1'b0);
    tick();
    n_tests++; if ({mem_we, mem_addr} !== {1'b1, 6'd0}) begin n_fail++; $display("FAIL err_w0: got %b/%0d want 1/0", mem_we, mem_addr); end
    drive(1'b1, 1'b0, 3'b000, 25'h5, 1'b0);
    tick();
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL err_bad_we: got %b want 0", mem_we); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    n_tests++; if ({mem_addr, mem_wdata} !== {6'd0, 32'h40}) begin n_fail++; $display("FAIL err_hold: got %0d/%h want 0/00000040", mem_addr, mem_wdata); end
    drive(1'b1, 1'b1, 3'b010, 25'h3, 1'b1);
    tick();
    in_valid = 1'b0;
    n_tests++; if ({mem_we, mem_addr} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL err_w1: got %b/%0d want 1/1", mem_we, mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0000_00C4) begin n_fail++; $display("FAIL err_w1_data: got %h want 000000c4", mem_wdata); end
    tick();
    n_tests++; if (count !== 7'd2) begin n_fail++; $display("FAIL err_count: got %0d want 2", count); end
    n_tests++; if ({err, done} !== 2'b11) begin n_fail++; $display("FAIL err_sticky_done: got %b want 11", {err, done}); end
    do_start();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared_by_start: got %b want 0", err); end
    rst = 1'b1; #1; rst = 1'b0;
  endtask

  task automatic test_depth();
    do_start();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 3'b000, 25'(k), 1'b0);
      n_tests++; if (in_ready_b !== (k < 4)) begin n_fail++; $display("FAIL depth_ready[%0d]: got %b want %b", k, in_ready_b, k < 4); end
      tick();
      if (k < 4) begin
        n_tests++; if ({mem_we_b, mem_addr_b} !== {1'b1, 6'(k)}) begin n_fail++; $display("FAIL depth_w[%0d]: got %b/%0d want 1/%0d", k, mem_we_b, mem_addr_b, k); end
        n_tests++; if (mem_wdata_b !== 32'(k) << 6) begin n_fail++; $display("FAIL depth_wdata[%0d]: got %h want %h", k, mem_wdata_b, 32'(k) << 6); end
      end else begin
        n_tests++; if (mem_we_b !== 1'b0) begin n_fail++; $display("FAIL depth_no_we[%0d]: got %b want 0", k, mem_we_b); end
      end
    end
    in_valid = 1'b0;
    n_tests++; if (count_b !== 7'd4) begin n_fail++; $display("FAIL depth_count: got %0d want 4", count_b); end
    n_tests++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL depth_done: got %b want 1", done_b); end
    n_tests++; if (mem_addr_b !== 6'd3) begin n_fail++; $display("FAIL depth_addr_hold: got %0d want 3", mem_addr_b); end
  endtask

  task automatic test_async_reset();
    rst = 1'b1; #1; rst = 1'b0;
    do_start();
    drive(1'b0, 1'b0, 3'b111, 25'h2, 1'b0);
    tick();
    tick();
    n_tests++; if ({mem_we, mem_addr} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL areset_pre: got %b/%0d want 1/1", mem_we, mem_addr); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({mem_we, in_ready, done, err} !== 4'b0000) begin n_fail++; $display("FAIL areset_flags: got %b want 0000", {mem_we, in_ready, done, err}); end
    n_tests++; if ({mem_addr, mem_wdata, count} !== 45'd0) begin n_fail++; $display("FAIL areset_regs: got %0d/%h/%0d want 0/0/0", mem_addr, mem_wdata, count); end
    tick();
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL areset_no_we: got %b want 0", mem_we); end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    do_start();
    drive(1'b1, 1'b1, 3'b010, 25'h3, 1'b1);
    tick();
    in_valid = 1'b0;
    n_tests++; if ({mem_we, mem_addr, count} !== {1'b1, 6'd0, 7'd0}) begin n_fail++; $display("FAIL areset_restart: got %b/%0d/%0d want 1/0/0", mem_we, mem_addr, count); end
    tick();
    n_tests++; if (count !== 7'd1) begin n_fail++; $display("FAIL areset_restart_count: got %0d want 1", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_encode();
    test_back_to_back();
    test_err();
    test_depth();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
